// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus between the ALU and LSB result producers.
// Each producer pushes {value, ROB index} into a private FIFO; a round-robin arbiter
// pops at most one head per cycle into a registered CDB broadcast.
// Optional feature macro: CDB_ARB_BYPASS_EN lets an empty source's live input compete
// directly for the CDB, cutting latency from 2 cycles to 1.
// Ports:
//   clk, rst (sync, active-high), rdy (0 freezes all state), jump_wrong (flush)
//   alu_valid/alu_ready/alu_val/alu_rob  ALU result push
//   lsb_valid/lsb_ready/lsb_val/lsb_rob  LSB result push
//   cdb_valid/cdb_val/cdb_rob/cdb_src    registered broadcast (src 0 = ALU, 1 = LSB)
module cdb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ROB_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             jump_wrong,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [31:0]      alu_val,
  input  logic [ROB_W-1:0] alu_rob,
  input  logic             lsb_valid,
  output logic             lsb_ready,
  input  logic [31:0]      lsb_val,
  input  logic [ROB_W-1:0] lsb_rob,
  output logic             cdb_valid,
  output logic [31:0]      cdb_val,
  output logic [ROB_W-1:0] cdb_rob,
  output logic             cdb_src
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NSRC   = 2;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [ROB_W-1:0]  rob;
  } ent_t;

  ent_t             mem_q  [NSRC][FIFO_DEPTH];
  ent_t             mem_d  [NSRC][FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q [NSRC];
  logic [PTR_W-1:0] wptr_d [NSRC];
  logic [PTR_W-1:0] rptr_q [NSRC];
  logic [PTR_W-1:0] rptr_d [NSRC];
  logic [CNT_W-1:0] cnt_q  [NSRC];
  logic [CNT_W-1:0] cnt_d  [NSRC];
  logic             last_grant_q, last_grant_d;
  logic             cdb_valid_q, cdb_valid_d;
  ent_t             cdb_ent_q, cdb_ent_d;
  logic             cdb_src_q, cdb_src_d;

  logic live;
  logic in_valid [NSRC];
  ent_t in_ent   [NSRC];
  logic ready    [NSRC];
  logic empty    [NSRC];
  logic push     [NSRC];
  logic cand     [NSRC];
  logic sel      [NSRC];
  logic pop      [NSRC];
  logic wr       [NSRC];

  assign live        = rdy && !rst && !jump_wrong;
  assign in_valid[0] = alu_valid;
  assign in_valid[1] = lsb_valid;
  assign in_ent[0]   = '{val: alu_val, rob: alu_rob};
  assign in_ent[1]   = '{val: lsb_val, rob: lsb_rob};

  // Candidate selection and round-robin grant; last_grant_q = 1 means LSB went last.
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      empty[s] = (cnt_q[s] == '0);
      ready[s] = live && (cnt_q[s] != CNT_W'(FIFO_DEPTH));
      push[s]  = in_valid[s] && ready[s];
`ifdef CDB_ARB_BYPASS_EN
      cand[s]  = !empty[s] || push[s];
`else
      cand[s]  = !empty[s];
`endif
    end
    sel[0] = cand[0] && (!cand[1] || last_grant_q);
    sel[1] = cand[1] && !sel[0];
    for (int s = 0; s < NSRC; s++) begin
      pop[s] = sel[s] && !empty[s];
      // A granted live input on an empty FIFO goes straight to the CDB instead.
      wr[s]  = push[s] && !(sel[s] && empty[s]);
    end
  end

  // Next-state: reset, flush, normal operation, or freeze.
  always_comb begin
    mem_d        = mem_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_ent_d    = cdb_ent_q;
    cdb_src_d    = cdb_src_q;
    if (rst || jump_wrong) begin
      for (int s = 0; s < NSRC; s++) begin
        wptr_d[s] = '0;
        rptr_d[s] = '0;
        cnt_d[s]  = '0;
      end
      cdb_valid_d = 1'b0;
      if (rst) begin
        last_grant_d = 1'b1;
        cdb_ent_d    = '0;
        cdb_src_d    = 1'b0;
      end
    end else if (rdy) begin
      cdb_valid_d = cand[0] || cand[1];
      for (int s = 0; s < NSRC; s++) begin
        if (sel[s]) begin
          cdb_ent_d    = empty[s] ? in_ent[s] : mem_q[s][rptr_q[s]];
          cdb_src_d    = 1'(s);
          last_grant_d = 1'(s);
        end
        if (wr[s]) begin
          mem_d[s][wptr_q[s]] = in_ent[s];
          wptr_d[s]           = wptr_q[s] + PTR_W'(1);
        end
        if (pop[s]) begin
          rptr_d[s] = rptr_q[s] + PTR_W'(1);
        end
        cnt_d[s] = cnt_q[s] + CNT_W'(wr[s]) - CNT_W'(pop[s]);
      end
    end
  end

  // State registers; reset is folded into the next-state logic.
  always_ff @(posedge clk) begin
    mem_q        <= mem_d;
    wptr_q       <= wptr_d;
    rptr_q       <= rptr_d;
    cnt_q        <= cnt_d;
    last_grant_q <= last_grant_d;
    cdb_valid_q  <= cdb_valid_d;
    cdb_ent_q    <= cdb_ent_d;
    cdb_src_q    <= cdb_src_d;
  end

  assign alu_ready = ready[0];
  assign lsb_ready = ready[1];
  assign cdb_valid = cdb_valid_q;
  assign cdb_val   = cdb_ent_q.val;
  assign cdb_rob   = cdb_ent_q.rob;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus random traffic on cdb_arbiter, checked every
// cycle against a queue-based model of the two FIFOs and the round-robin bus.
module tb_cdb_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned ROB_W = 4;
`ifdef CDB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]      v;
    logic [ROB_W-1:0] r;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rdy = 1'b1;
  logic             jump_wrong = 1'b0;
  logic             alu_valid = 1'b0;
  logic             alu_ready;
  logic [31:0]      alu_val = '0;
  logic [ROB_W-1:0] alu_rob = '0;
  logic             lsb_valid = 1'b0;
  logic             lsb_ready;
  logic [31:0]      lsb_val = '0;
  logic [ROB_W-1:0] lsb_rob = '0;
  logic             cdb_valid;
  logic [31:0]      cdb_val;
  logic [ROB_W-1:0] cdb_rob;
  logic             cdb_src;

  cdb_arbiter #(.FIFO_DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_val(alu_val), .alu_rob(alu_rob),
    .lsb_valid(lsb_valid), .lsb_ready(lsb_ready), .lsb_val(lsb_val), .lsb_rob(lsb_rob),
    .cdb_valid(cdb_valid), .cdb_val(cdb_val), .cdb_rob(cdb_rob), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model state: pending results per source and the expected bus registers.
  ent_t        qa[$];
  ent_t        ql[$];
  bit          e_valid = 1'b0;
  logic [31:0] e_val   = '0;
  logic [ROB_W-1:0] e_rob = '0;
  bit          e_src   = 1'b0;
  bit          e_last  = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check readiness, advance the model, check the bus.
  task automatic cycle(input bit r, input bit j, input bit y,
                       input bit av, input ent_t ae, input bit lv, input ent_t le);
    bit ra, rl, pa, pl, ca, cl, g, ga, gl;
    ent_t took;
    rst = r; jump_wrong = j; rdy = y;
    alu_valid = av; alu_val = ae.v; alu_rob = ae.r;
    lsb_valid = lv; lsb_val = le.v; lsb_rob = le.r;
    #1;
    ra = y && !r && !j && (qa.size() < DEPTH);
    rl = y && !r && !j && (ql.size() < DEPTH);
    check("alu_ready", 64'(alu_ready), 64'(ra));
    check("lsb_ready", 64'(lsb_ready), 64'(rl));
    pa = av && ra;
    pl = lv && rl;
    if (r) begin
      qa.delete(); ql.delete();
      e_valid = 1'b0; e_val = '0; e_rob = '0; e_src = 1'b0; e_last = 1'b1;
    end else if (j) begin
      qa.delete(); ql.delete();
      e_valid = 1'b0;
    end else if (y) begin
      ca = (qa.size() > 0) || (BYP && pa);
      cl = (ql.size() > 0) || (BYP && pl);
      ga = 1'b0; gl = 1'b0;
      if (ca || cl) begin
        g = (ca && cl) ? !e_last : cl;
        if (!g) begin
          if (qa.size() > 0) took = qa.pop_front();
          else begin took = ae; ga = 1'b1; end
        end else begin
          if (ql.size() > 0) took = ql.pop_front();
          else begin took = le; gl = 1'b1; end
        end
        e_valid = 1'b1; e_val = took.v; e_rob = took.r; e_src = g; e_last = g;
      end else begin
        e_valid = 1'b0;
      end
      if (pa && !ga) qa.push_back(ae);
      if (pl && !gl) ql.push_back(le);
    end
    @(posedge clk);
    #1;
    check("cdb_valid", 64'(cdb_valid), 64'(e_valid));
    check("cdb_val",   64'(cdb_val),   64'(e_val));
    check("cdb_rob",   64'(cdb_rob),   64'(e_rob));
    check("cdb_src",   64'(cdb_src),   64'(e_src));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    ent_t a, l;
    int   seen;
    @(posedge clk);
    #1;
    // Reset for two cycles, then an idle cycle with both FIFOs open.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, '{v: 32'hdead, r: 4'd1}, 1'b1, '{v: 32'hbeef, r: 4'd2});
    cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    idle(1);

    // Single ALU push; count the broadcast pulses it produces.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, '{v: 32'h12345678, r: 4'd3}, 1'b0, '0);
    seen = (cdb_valid === 1'b1) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (cdb_valid === 1'b1) seen++;
    end
    check("single_push_pulses", 64'(seen), 64'd1);

    // Simultaneous push after reset: ALU first, then LSB.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, '{v: 32'haaaa0001, r: 4'd5}, 1'b1, '{v: 32'hbbbb0001, r: 4'd6});
    idle(3);

    // Both sources push every cycle with rising rob numbers.
    for (int i = 0; i < 10; i++) begin
      a = '{v: 32'h1000 + 32'(i), r: ROB_W'(i)};
      l = '{v: 32'h2000 + 32'(i), r: ROB_W'(i)};
      cycle(1'b0, 1'b0, 1'b1, 1'b1, a, 1'b1, l);
    end
    idle(12);

    // Buffer several entries, flush with jump_wrong, confirm nothing leaks out.
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 1'b1, 1'b1, '{v: 32'h3000 + 32'(i), r: ROB_W'(i)},
            1'b1, '{v: 32'h4000 + 32'(i), r: ROB_W'(i)});
    cycle(1'b0, 1'b1, 1'b1, 1'b1, '{v: 32'h3fff, r: 4'hf}, 1'b0, '0);
    idle(4);

    // Buffer entries, freeze with rdy=0 (inputs offered but refused), then drain.
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 1'b1, 1'b1, '{v: 32'h5000 + 32'(i), r: ROB_W'(i)},
            1'b1, '{v: 32'h6000 + 32'(i), r: ROB_W'(i)});
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 1'b0, 1'b1, '{v: 32'h7777, r: 4'd7}, 1'b1, '{v: 32'h8888, r: 4'd8});
    idle(8);

    // Random traffic, including freezes, flushes and the occasional reset.
    for (int i = 0; i < 3000; i++) begin
      a = '{v: $urandom, r: ROB_W'($urandom)};
      l = '{v: $urandom, r: ROB_W'($urandom)};
      cycle(($urandom % 300) == 0, ($urandom % 80) == 0, ($urandom % 8) != 0,
            ($urandom % 4) != 0, a, ($urandom % 3) != 0, l);
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
